// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage and IF/ID pipeline register of the
//            5-stage RV32I core.
//
// Owns the fetch PC and keeps at most one request in flight to instruction
// memory over a req/valid handshake. The IF/ID register feeds ID, and the
// stage obeys the stall (IFWrite) and redirect (Branch/Jump) controls that
// come back from ID.
//
// Optional feature macro: IF_PERF_CNT_EN
//   When defined, the fetch_cnt/stall_cnt performance counters are added.
//
// Ports
//   clk            core clock, every register updates on the rising edge
//   rst_n          asynchronous active-low reset
//   IFWrite        0 = hold the PC and IF/ID (load-use stall)
//   Branch         conditional branch taken (target in BranchAddr)
//   Jump           JAL/JALR (target in JumpAddr); wins over Branch
//   JumpAddr       jump target
//   BranchAddr     branch target
//   imem_req       fetch request, held until imem_valid
//   imem_addr      fetch address, always word aligned
//   imem_valid     one-cycle response strobe
//   imem_rdata     fetched instruction, qualified by imem_valid
//   Instruction_id IF/ID instruction (NOP_INSTR for a bubble)
//   PC_id          IF/ID program counter
//   valid_id       1 = Instruction_id is a real fetched instruction
//   fetch_cnt      (IF_PERF_CNT_EN) count of valid loads into IF/ID
//   stall_cnt      (IF_PERF_CNT_EN) count of cycles with IFWrite=0
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_e;

  // The PC register only ever holds word-aligned values, so imem_addr can be
  // driven straight from it.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcid_q, pcid_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_q, hold_d;

  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;
  logic        load_valid_s;

  assign redirect_s = IFWrite & (Branch | Jump);
  assign target_s   = Jump ? {JumpAddr[31:2], 2'b00} : {BranchAddr[31:2], 2'b00};
  assign pc_inc_s   = pc_q + 32'd4;

  // Next-state, PC and IF/ID selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcid_d       = pcid_q;
    valid_d      = valid_q;
    hold_d       = hold_q;
    load_valid_s = 1'b0;

    case (state_q)
      // First cycle out of reset: anything on imem_valid belongs to a request
      // issued before reset and is ignored.
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect_s) begin
          // Flush the wrong-path slot; a response landing this cycle is
          // dropped, otherwise the one still in flight must be swallowed.
          instr_d = NOP_INSTR;
          pcid_d  = pc_q;
          valid_d = 1'b0;
          pc_d    = target_s;
          hold_d  = NOP_INSTR;
          state_d = imem_valid ? FETCH : KILL;
        end else if (IFWrite) begin
          if (imem_valid) begin
            instr_d      = imem_rdata;
            pcid_d       = pc_q;
            valid_d      = 1'b1;
            pc_d         = pc_inc_s;
            load_valid_s = 1'b1;
          end else begin
            instr_d = NOP_INSTR;
            pcid_d  = pc_q;
            valid_d = 1'b0;
          end
        end else if (imem_valid) begin
          // ID is stalled: park the instruction until IF/ID may advance.
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end

      HOLD: begin
        if (redirect_s) begin
          instr_d = NOP_INSTR;
          pcid_d  = pc_q;
          valid_d = 1'b0;
          pc_d    = target_s;
          hold_d  = NOP_INSTR;
          state_d = FETCH;
        end else if (IFWrite) begin
          instr_d      = hold_q;
          pcid_d       = pc_q;
          valid_d      = 1'b1;
          pc_d         = pc_inc_s;
          hold_d       = NOP_INSTR;
          load_valid_s = 1'b1;
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end

      KILL: begin
        // No new request until the stale response has been seen; a further
        // redirect just moves the restart PC.
        if (IFWrite) begin
          instr_d = NOP_INSTR;
          pcid_d  = pc_q;
          valid_d = 1'b0;
        end else begin
          instr_d = instr_q;
        end
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end else begin
          state_d = KILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == FETCH);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      req_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      pcid_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      pcid_q  <= pcid_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign Instruction_id = instr_q;
  assign PC_id          = pcid_q;
  assign valid_id       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, load_valid_s};
      stall_cnt_q <= stall_cnt_q + {31'd0, ~IFWrite};
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A directed vector table (fixed one-cycle memory latency) covers streaming,
// stall with buffering, jump/branch flush, priority, alignment and PC wrap.
// An asynchronous reset in mid-fetch is then checked, followed by a long
// randomized run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IFWrite = 1'b1;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] JumpAddr = 32'h0;
  logic [31:0] BranchAddr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction_id;
  logic [31:0] PC_id;
  logic        valid_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFWrite       (IFWrite),
    .Branch        (Branch),
    .Jump          (Jump),
    .JumpAddr      (JumpAddr),
    .BranchAddr    (BranchAddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .Instruction_id(Instruction_id),
    .PC_id         (PC_id),
    .valid_id      (valid_id)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one request at a time, returns addr|0x13 after lat cycles.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;   // 0 selects a random latency of 1..3
  logic [31:0] mem_addr = 32'h0;

  task automatic mem_cycle();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (mem_busy) begin
      if (imem_req) chk("addr_stable", imem_addr, mem_addr);
      if (mem_cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem_addr | 32'h0000_0013;
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_instr"}, Instruction_id, NOP);
    chk({tag, "_pc"},    PC_id, 32'h0);
    chk({tag, "_valid"}, {31'd0, valid_id}, 32'd0);
  endtask

  typedef struct {
    logic        ifw, br, jp;
    logic [31:0] ja, ba;
    logic        ev;
    logic [31:0] ei, ep;
    logic        ereq;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[24];

  // Reference model state (transaction level).
  bit          m_started, m_buf_full, m_discard;
  logic [31:0] m_buf, m_pc, e_instr, e_pc;
  logic        e_valid;
  int          m_fetches, m_stalls;

  initial begin
    // in: ifw br jp ja ba | exp after edge: valid instr pc_id req addr
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h0,          1'b1,32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h0,          1'b1,32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h13,       32'h0,          1'b1,32'h4};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h4,          1'b1,32'h4};
    tbl[4]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h17,       32'h4,          1'b1,32'h8};
    tbl[5]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h8,          1'b1,32'h8};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h1b,       32'h8,          1'b1,32'hc};
    tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'hc,          1'b1,32'hc};
    tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'hc,          1'b0,32'hc};
    tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'hc,          1'b0,32'hc};
    tbl[10] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h1f,       32'hc,          1'b1,32'h10};
    tbl[11] = '{1'b1,1'b0,1'b1,32'h100,32'h0,         1'b0,NOP,          32'h10,         1'b0,32'h100};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h100,        1'b1,32'h100};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h100,        1'b1,32'h100};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h113,      32'h100,        1'b1,32'h104};
    tbl[15] = '{1'b1,1'b1,1'b1,32'h300,32'h200,       1'b0,NOP,          32'h104,        1'b0,32'h300};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h300,        1'b1,32'h300};
    tbl[17] = '{1'b0,1'b1,1'b0,32'h0,32'h200,         1'b0,NOP,          32'h300,        1'b1,32'h300};
    tbl[18] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'h313,      32'h300,        1'b1,32'h304};
    tbl[19] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFF,32'h0,   1'b0,NOP,          32'h304,        1'b0,32'hFFFF_FFFC};
    tbl[20] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'hFFFF_FFFC,  1'b1,32'hFFFF_FFFC};
    tbl[21] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'hFFFF_FFFC,  1'b1,32'hFFFF_FFFC};
    tbl[22] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b1,32'hFFFF_FFFF,32'hFFFF_FFFC,  1'b1,32'h0};
    tbl[23] = '{1'b1,1'b0,1'b0,32'h0,32'h0,           1'b0,NOP,          32'h0,          1'b1,32'h0};

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Directed table with one-cycle memory latency.
    mem_lat = 1;
    for (int i = 0; i < 24; i++) begin
      IFWrite    = tbl[i].ifw;
      Branch     = tbl[i].br;
      Jump       = tbl[i].jp;
      JumpAddr   = tbl[i].ja;
      BranchAddr = tbl[i].ba;
      mem_cycle();
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid_id}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_instr", i), Instruction_id, tbl[i].ei);
      chk($sformatf("tbl%0d_pc", i),    PC_id, tbl[i].ep);
      chk($sformatf("tbl%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].ereq});
      chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].ea);
    end

    // Asynchronous reset in the middle of a fetch (request to 0 outstanding).
    IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_busy = 1'b0;

    // Randomized run against the reference model. The first cycle after
    // release carries a stale response that must be ignored.
    mem_lat    = 0;
    m_started  = 1'b0; m_buf_full = 1'b0; m_discard = 1'b0;
    m_buf      = NOP;  m_pc = 32'h0;
    e_instr    = NOP;  e_pc = 32'h0; e_valid = 1'b0;
    m_fetches  = 0;    m_stalls = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        redir;
      logic [31:0] tgt;
      if (c == 0) begin
        IFWrite = 1'b1; Branch = 1'b1; Jump = 1'b1; JumpAddr = 32'h0000_0800;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else begin
        IFWrite    = ($urandom_range(0, 9) < 8);
        Branch     = ($urandom_range(0, 9) == 0);
        Jump       = ($urandom_range(0, 11) == 0);
        JumpAddr   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        BranchAddr = $urandom;
        mem_cycle();
      end

      redir = IFWrite && (Branch || Jump);
      tgt   = (Jump ? JumpAddr : BranchAddr) & 32'hFFFF_FFFC;
      if (!IFWrite) m_stalls++;
      if (!m_started) begin
        m_started = 1'b1;
      end else if (m_discard) begin
        if (IFWrite) begin e_instr = NOP; e_pc = m_pc; e_valid = 1'b0; end
        if (redir) m_pc = tgt;
        if (imem_valid) m_discard = 1'b0;
      end else if (m_buf_full) begin
        if (IFWrite) begin
          if (redir) begin
            e_instr = NOP; e_pc = m_pc; e_valid = 1'b0; m_pc = tgt;
          end else begin
            e_instr = m_buf; e_pc = m_pc; e_valid = 1'b1; m_pc = m_pc + 32'd4; m_fetches++;
          end
          m_buf_full = 1'b0;
        end
      end else begin
        if (IFWrite) begin
          if (redir) begin
            e_instr = NOP; e_pc = m_pc; e_valid = 1'b0; m_pc = tgt;
            if (!imem_valid) m_discard = 1'b1;
          end else if (imem_valid) begin
            e_instr = imem_rdata; e_pc = m_pc; e_valid = 1'b1; m_pc = m_pc + 32'd4; m_fetches++;
          end else begin
            e_instr = NOP; e_pc = m_pc; e_valid = 1'b0;
          end
        end else if (imem_valid) begin
          m_buf = imem_rdata; m_buf_full = 1'b1;
        end
      end

      @(posedge clk);
      #1;
      chk("rnd_valid", {31'd0, valid_id}, {31'd0, e_valid});
      chk("rnd_instr", Instruction_id, e_instr);
      chk("rnd_pc",    PC_id, e_pc);
      chk("rnd_req",   {31'd0, imem_req}, {31'd0, (m_started && !m_buf_full && !m_discard)});
      chk("rnd_addr",  imem_addr, m_pc);
    end

`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetches);
    chk("stall_cnt", stall_cnt, m_stalls);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
